// File: rtl/pwm_capture_if.sv
// Measurement bus published by pwm_capture: results, pulses and stuck-level flag.
interface pwm_capture_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic [CNT_WIDTH-1:0] high_cycles;
  logic [CNT_WIDTH-1:0] period_cycles;
  logic                 measure_valid;
  logic [3:0]           meas_count;
  logic                 timeout;
  logic                 stuck_level;

  // Producer side (the capture block)
  modport master (
    output high_cycles,
    output period_cycles,
    output measure_valid,
    output meas_count,
    output timeout,
    output stuck_level
  );

  // Consumer side (host / monitor)
  modport slave (
    input high_cycles,
    input period_cycles,
    input measure_valid,
    input meas_count,
    input timeout,
    input stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an asynchronous
// PWM input in clk cycles, publishes one result per completed period and
// reports stuck-level inputs via a timeout.
module pwm_capture #(
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 32'hFFF0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwm_in,
  input  logic          capture_enable,
  pwm_capture_if.master meas
);

  localparam int unsigned MCNT_WIDTH = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   sync_c;
  logic                   rise_c;
  logic                   fall_c;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_inc_c;
  logic [CNT_WIDTH-1:0]  high_hold_q, high_hold_d;
  logic [CNT_WIDTH-1:0]  high_cycles_q, high_cycles_d;
  logic [CNT_WIDTH-1:0]  period_cycles_q, period_cycles_d;
  logic                  measure_valid_q, measure_valid_d;
  logic [MCNT_WIDTH-1:0] meas_count_q, meas_count_d;
  logic                  timeout_q, timeout_d;
  logic                  stuck_level_q, stuck_level_d;

  assign sync_c = sync_q[SYNC_STAGES-1];
  assign rise_c = sync_c & ~prev_q;
  assign fall_c = ~sync_c & prev_q;

  // Saturating increment so very long phases never wrap into a short value
  assign cnt_inc_c = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Synchronizer chain and edge-history flop; kept running while disabled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= sync_c;
    end
  end

  // Next-state, counter and publish logic
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    high_hold_d     = high_hold_q;
    high_cycles_d   = high_cycles_q;
    period_cycles_d = period_cycles_q;
    measure_valid_d = 1'b0;
    meas_count_d    = meas_count_q;
    timeout_d       = 1'b0;
    stuck_level_d   = stuck_level_q;

    if (!capture_enable) begin
      state_d     = ST_IDLE;
      cnt_d       = CNT_ZERO;
      high_hold_d = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = CNT_ZERO;
          // First partial period is discarded: just start counting
          if (rise_c) begin
            state_d = ST_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        ST_HIGH: begin
          cnt_d = cnt_inc_c;
          if (fall_c) begin
            high_hold_d = cnt_q;
            state_d     = ST_LOW;
          end else if (cnt_q == TIMEOUT_CNT) begin
            state_d       = ST_IDLE;
            cnt_d         = CNT_ZERO;
            timeout_d     = 1'b1;
            stuck_level_d = sync_c;
          end
        end
        ST_LOW: begin
          cnt_d = cnt_inc_c;
          if (rise_c) begin
            period_cycles_d = cnt_q;
            high_cycles_d   = high_hold_q;
            measure_valid_d = 1'b1;
            meas_count_d    = meas_count_q + MCNT_WIDTH'(1);
            cnt_d           = CNT_ONE;
            state_d         = ST_HIGH;
          end else if (cnt_q == TIMEOUT_CNT) begin
            state_d       = ST_IDLE;
            cnt_d         = CNT_ZERO;
            timeout_d     = 1'b1;
            stuck_level_d = sync_c;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= CNT_ZERO;
      high_hold_q     <= CNT_ZERO;
      high_cycles_q   <= CNT_ZERO;
      period_cycles_q <= CNT_ZERO;
      measure_valid_q <= 1'b0;
      meas_count_q    <= '0;
      timeout_q       <= 1'b0;
      stuck_level_q   <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      high_hold_q     <= high_hold_d;
      high_cycles_q   <= high_cycles_d;
      period_cycles_q <= period_cycles_d;
      measure_valid_q <= measure_valid_d;
      meas_count_q    <= meas_count_d;
      timeout_q       <= timeout_d;
      stuck_level_q   <= stuck_level_d;
    end
  end

  assign meas.high_cycles   = high_cycles_q;
  assign meas.period_cycles = period_cycles_q;
  assign meas.measure_valid = measure_valid_q;
  assign meas.meas_count    = meas_count_q;
  assign meas.timeout       = timeout_q;
  assign meas.stuck_level   = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a measurement scoreboard.
module tb_pwm_capture;

  localparam int unsigned CW = 16;
  localparam int unsigned TO = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic pwm_in;
  logic capture_enable;

  always #5 clk = ~clk;

  pwm_capture_if #(.CNT_WIDTH(CW)) meas_if ();

  pwm_capture #(
    .CNT_WIDTH   (CW),
    .SYNC_STAGES (2),
    .TIMEOUT     (TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pwm_in         (pwm_in),
    .capture_enable (capture_enable),
    .meas           (meas_if)
  );

  typedef struct {
    logic [CW-1:0] hi;
    logic [CW-1:0] per;
    logic [3:0]    cnt;
  } meas_t;

  meas_t sb[$];
  logic  to_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_rise_cyc = 0;

  logic          m_have;
  logic [CW-1:0] m_hi;
  logic [CW-1:0] m_per;
  logic [3:0]    exp_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a level for n cycles, remembering when each input rise happened
  task automatic drive(input logic lvl, input int n);
    if (lvl && !pwm_in) last_rise_cyc = cyc;
    pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // A new rise closes the previous period, if one was being measured
  task automatic new_rise(input int h, input int per);
    if (m_have) begin
      exp_cnt = exp_cnt + 4'd1;
      sb.push_back('{hi: m_hi, per: m_per, cnt: exp_cnt});
    end
    m_hi   = CW'(h);
    m_per  = CW'(per);
    m_have = 1'b1;
  endtask

  task automatic pulse(input int h, input int l);
    new_rise(h, h + l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic monitor();
    meas_t e;
    logic  lvl;
    forever begin
      @(negedge clk);
      if (meas_if.measure_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("high_cycles", 32'(meas_if.high_cycles), 32'(e.hi));
          check("period_cycles", 32'(meas_if.period_cycles), 32'(e.per));
          check("meas_count", 32'(meas_if.meas_count), 32'(e.cnt));
          check("valid_latency", 32'(cyc - last_rise_cyc), 32'(3));
        end
      end
      if (meas_if.timeout) begin
        if (to_q.size() == 0) begin
          check("unexpected_timeout", 32'(1), 32'(0));
        end else begin
          lvl = to_q.pop_front();
          check("stuck_level", 32'(meas_if.stuck_level), 32'(lvl));
        end
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    pwm_in         = 1'b0;
    capture_enable = 1'b1;
    m_have         = 1'b0;
    m_hi           = '0;
    m_per          = '0;
    exp_cnt        = 4'd0;
    fork
      monitor();
    join_none

    // Reset with a toggling input
    @(negedge clk); pwm_in = 1'b1;
    @(negedge clk); pwm_in = 1'b0;
    @(negedge clk); pwm_in = 1'b1;
    @(negedge clk);
    check("rst_high", 32'(meas_if.high_cycles), 32'(0));
    check("rst_period", 32'(meas_if.period_cycles), 32'(0));
    check("rst_valid", 32'(meas_if.measure_valid), 32'(0));
    check("rst_count", 32'(meas_if.meas_count), 32'(0));
    check("rst_timeout", 32'(meas_if.timeout), 32'(0));
    check("rst_stuck", 32'(meas_if.stuck_level), 32'(0));
    pwm_in = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal 24/72
    repeat (4) pulse(24, 48);

    // Duty change on the fly
    repeat (2) pulse(10, 30);
    repeat (2) pulse(30, 10);

    // Stuck low
    to_q.push_back(1'b0);
    pulse(20, 150);
    m_have = 1'b0;
    repeat (3) pulse(24, 48);

    // Stuck high
    to_q.push_back(1'b1);
    new_rise(0, 0);
    drive(1'b1, 150);
    m_have = 1'b0;
    check("stuckhi_high", 32'(meas_if.high_cycles), 32'(24));
    check("stuckhi_period", 32'(meas_if.period_cycles), 32'(72));
    check("stuckhi_count", 32'(meas_if.meas_count), 32'(11));
    check("stuckhi_level", 32'(meas_if.stuck_level), 32'(1));
    drive(1'b0, 20);

    // capture_enable dropped during LOW
    repeat (2) pulse(20, 40);
    new_rise(20, 60);
    drive(1'b1, 20);
    drive(1'b0, 10);
    capture_enable = 1'b0;
    repeat (5) @(negedge clk);
    check("dis_high", 32'(meas_if.high_cycles), 32'(20));
    check("dis_period", 32'(meas_if.period_cycles), 32'(60));
    check("dis_count", 32'(meas_if.meas_count), 32'(13));
    capture_enable = 1'b1;
    m_have = 1'b0;
    drive(1'b0, 25);
    repeat (2) pulse(20, 40);

    // Reset in the middle of HIGH
    new_rise(10, 10);
    drive(1'b1, 10);
    rst_n = 1'b0;
    @(negedge clk);
    pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_high", 32'(meas_if.high_cycles), 32'(0));
    check("midrst_period", 32'(meas_if.period_cycles), 32'(0));
    check("midrst_count", 32'(meas_if.meas_count), 32'(0));
    check("midrst_valid", 32'(meas_if.measure_valid), 32'(0));
    exp_cnt = 4'd0;
    m_have  = 1'b0;
    rst_n   = 1'b1;
    drive(1'b0, 10);

    // meas_count wrap 15 -> 0, then a final stuck-low timeout
    repeat (17) pulse(24, 20);
    to_q.push_back(1'b0);
    repeat (120) @(negedge clk);
    check("wrap_count", 32'(meas_if.meas_count), 32'(0));
    check("sb_drained", 32'(sb.size()), 32'(0));
    check("timeouts_seen", 32'(to_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
